// File: rtl/hh_counter24.sv
// Two independent modulo-24 BCD hour registers (clock and alarm) with display
// mux, day-rollover pulse and alarm-hour match detection.
module hh_counter24 #(
  parameter int CLK_INIT = 0,
  parameter int ALM_INIT = 7
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       up_clock24,
  input  logic       up_alarm24,
  input  logic       clock_alarm,
  output logic [7:0] clk_hh,
  output logic [7:0] alm_hh,
  output logic [7:0] disp_hh,
  output logic       carry_day,
  output logic       hh_match,
  output logic       match_rise
);

  localparam logic [7:0] CLK_RST = 8'(((CLK_INIT / 10) * 16) + (CLK_INIT % 10));
  localparam logic [7:0] ALM_RST = 8'(((ALM_INIT / 10) * 16) + (ALM_INIT % 10));
  localparam logic [7:0] HH_LAST = 8'h23;

  // Next BCD hour. 23 and every illegal code (24..29, tens > 2, units > 9)
  // share one path to 00, so an upset value self-heals on the next increment.
  function automatic logic [7:0] bcd_inc(input logic [7:0] h);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = h[7:4];
    units = h[3:0];
    if (tens > 4'd2 || units > 4'd9 || (tens == 4'd2 && units >= 4'd3))
      return 8'h00;
    else if (units == 4'd9)
      return {tens + 4'd1, 4'd0};
    else
      return {tens, units + 4'd1};
  endfunction

  logic [7:0] clk_next;
  logic [7:0] alm_next;
  logic       match_prev;

  always_comb begin
    clk_next = up_clock24 ? bcd_inc(clk_hh) : clk_hh;
    alm_next = up_alarm24 ? bcd_inc(alm_hh) : alm_hh;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; carry_day below relies on seeing the old clk_hh.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      clk_hh    <= CLK_RST;
      carry_day <= 1'b0;
    end else begin
      clk_hh    <= clk_next;
      carry_day <= up_clock24 && (clk_hh == HH_LAST);
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) alm_hh <= ALM_RST;
    else        alm_hh <= alm_next;
  end

  // History resets to 1 so an equal pair out of reset is not reported as a rise.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      match_prev <= 1'b1;
      match_rise <= 1'b0;
    end else begin
      match_prev <= hh_match;
      match_rise <= hh_match && !match_prev;
    end
  end

  assign hh_match = (clk_hh == alm_hh);
  assign disp_hh  = clock_alarm ? clk_hh : alm_hh;

endmodule

// File: tb/tb_hh_counter24.sv
// Self-checking bench for hh_counter24: reset state, directed vector table,
// 24-hour wrap, asynchronous mid-count reset and a randomized model comparison.
module tb_hh_counter24;

  logic       ck = 1'b0;
  logic       reset = 1'b0;
  logic       up_clock24 = 1'b0;
  logic       up_alarm24 = 1'b0;
  logic       clock_alarm = 1'b1;
  logic [7:0] clk_hh, alm_hh, disp_hh;
  logic       carry_day, hh_match, match_rise;

  int errors = 0;
  int checks = 0;

  hh_counter24 #(.CLK_INIT(0), .ALM_INIT(7)) dut (
    .ck(ck), .reset(reset), .up_clock24(up_clock24), .up_alarm24(up_alarm24),
    .clock_alarm(clock_alarm), .clk_hh(clk_hh), .alm_hh(alm_hh), .disp_hh(disp_hh),
    .carry_day(carry_day), .hh_match(hh_match), .match_rise(match_rise)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic       up_c;
    logic       up_a;
    logic       sel;
    logic [7:0] e_clk;
    logic [7:0] e_alm;
    logic [7:0] e_disp;
    logic       e_carry;
    logic       e_match;
    logic       e_rise;
  } vec_t;

  vec_t vecs[15];

  // Reference model: plain hour integers and the previous match level.
  int m_clk, m_alm;
  bit m_prev;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic do_reset();
    up_clock24 = 1'b0;
    up_alarm24 = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge ck);
    @(negedge ck);
    reset = 1'b1;
    m_clk = 0;
    m_alm = 7;
    m_prev = 1'b1;
  endtask

  // Drive inputs, take one rising edge, land 1 time unit after it.
  task automatic step(input logic uc, input logic ua, input logic sel);
    up_clock24  = uc;
    up_alarm24  = ua;
    clock_alarm = sel;
    @(posedge ck);
    #1;
  endtask

  // Advance the model by one edge and compare every output against it.
  task automatic model_step_check(input string tag, input logic uc, input logic ua, input logic sel);
    bit old_match, e_carry, e_rise;
    old_match = (m_clk == m_alm);
    e_carry   = uc && (m_clk == 23);
    if (uc) m_clk = (m_clk + 1) % 24;
    if (ua) m_alm = (m_alm + 1) % 24;
    e_rise = old_match && !m_prev;
    m_prev = old_match;
    check({tag, " clk_hh"}, clk_hh, bcd(m_clk));
    check({tag, " alm_hh"}, alm_hh, bcd(m_alm));
    check({tag, " disp_hh"}, disp_hh, sel ? bcd(m_clk) : bcd(m_alm));
    check({tag, " carry_day"}, {7'd0, carry_day}, {7'd0, e_carry});
    check({tag, " hh_match"}, {7'd0, hh_match}, {7'd0, m_clk == m_alm});
    check({tag, " match_rise"}, {7'd0, match_rise}, {7'd0, e_rise});
  endtask

  initial begin
    int carries;
    logic uc, ua, sel;

    // Directed table from reset state (00, 07).
    vecs[0]  = '{1, 1, 1, 8'h01, 8'h08, 8'h01, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 8'h02, 8'h08, 8'h08, 0, 0, 0};
    vecs[2]  = '{1, 0, 0, 8'h03, 8'h08, 8'h08, 0, 0, 0};
    vecs[3]  = '{1, 0, 1, 8'h04, 8'h08, 8'h04, 0, 0, 0};
    vecs[4]  = '{1, 0, 1, 8'h05, 8'h08, 8'h05, 0, 0, 0};
    vecs[5]  = '{1, 0, 0, 8'h06, 8'h08, 8'h08, 0, 0, 0};
    vecs[6]  = '{1, 0, 1, 8'h07, 8'h08, 8'h07, 0, 0, 0};
    vecs[7]  = '{1, 0, 1, 8'h08, 8'h08, 8'h08, 0, 1, 0};
    vecs[8]  = '{0, 0, 1, 8'h08, 8'h08, 8'h08, 0, 1, 1};
    vecs[9]  = '{0, 0, 1, 8'h08, 8'h08, 8'h08, 0, 1, 0};
    vecs[10] = '{0, 1, 0, 8'h08, 8'h09, 8'h09, 0, 0, 0};
    vecs[11] = '{1, 0, 1, 8'h09, 8'h09, 8'h09, 0, 1, 0};
    vecs[12] = '{0, 0, 1, 8'h09, 8'h09, 8'h09, 0, 1, 1};
    vecs[13] = '{0, 0, 0, 8'h09, 8'h09, 8'h09, 0, 1, 0};
    vecs[14] = '{1, 0, 1, 8'h10, 8'h09, 8'h10, 0, 0, 0};

    // Reset state, both display selections, quiet for 5 cycles.
    do_reset();
    #1;
    clock_alarm = 1'b1;
    #1;
    check("rst clk_hh", clk_hh, 8'h00);
    check("rst alm_hh", alm_hh, 8'h07);
    check("rst disp clk", disp_hh, 8'h00);
    clock_alarm = 1'b0;
    #1;
    check("rst disp alm", disp_hh, 8'h07);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1);
      check($sformatf("rst%0d carry_day", i), {7'd0, carry_day}, 8'h00);
      check($sformatf("rst%0d match_rise", i), {7'd0, match_rise}, 8'h00);
      check($sformatf("rst%0d clk_hh", i), clk_hh, 8'h00);
    end

    // Directed vectors.
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].up_c, vecs[i].up_a, vecs[i].sel);
      check($sformatf("vec%0d clk_hh", i), clk_hh, vecs[i].e_clk);
      check($sformatf("vec%0d alm_hh", i), alm_hh, vecs[i].e_alm);
      check($sformatf("vec%0d disp_hh", i), disp_hh, vecs[i].e_disp);
      check($sformatf("vec%0d carry_day", i), {7'd0, carry_day}, {7'd0, vecs[i].e_carry});
      check($sformatf("vec%0d hh_match", i), {7'd0, hh_match}, {7'd0, vecs[i].e_match});
      check($sformatf("vec%0d match_rise", i), {7'd0, match_rise}, {7'd0, vecs[i].e_rise});
    end

    // Full day: 24 held cycles from 00, one carry exactly at 00.
    do_reset();
    carries = 0;
    for (int i = 0; i < 24; i++) begin
      step(1, 0, 1);
      check($sformatf("wrap%0d clk_hh", i), clk_hh, bcd((i + 1) % 24));
      check($sformatf("wrap%0d alm_hh", i), alm_hh, 8'h07);
      check($sformatf("wrap%0d carry_day", i), {7'd0, carry_day}, {7'd0, i == 23});
      if (carry_day) carries++;
    end
    check("wrap carry count", 8'(carries), 8'd1);
    step(0, 0, 1);
    check("wrap carry drop", {7'd0, carry_day}, 8'h00);

    // Asynchronous reset between edges while an increment is requested at 15.
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 0, 1);
    check("mid clk_hh pre", clk_hh, 8'h15);
    #2;
    reset = 1'b0;
    #1;
    check("mid clk_hh async", clk_hh, 8'h00);
    check("mid alm_hh async", alm_hh, 8'h07);
    @(posedge ck);
    #1;
    check("mid clk_hh held", clk_hh, 8'h00);
    check("mid carry_day", {7'd0, carry_day}, 8'h00);
    up_clock24 = 1'b0;
    @(negedge ck);
    reset = 1'b1;
    step(0, 0, 1);
    check("mid clk_hh release", clk_hh, 8'h00);
    check("mid match_rise", {7'd0, match_rise}, 8'h00);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      uc  = ($urandom_range(0, 99) < 60);
      ua  = ($urandom_range(0, 99) < 30);
      sel = 1'($urandom);
      step(uc, ua, sel);
      model_step_check($sformatf("rnd%0d", i), uc, ua, sel);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
